hough_line_transform: RTL
=========================

# hough_line_transform

Streaming Hough line detector: the next-generation pipeline stage after the camera front end. It captures one flat greyscale frame over the Req/Ack handshake, thresholds each pixel into an edge bit, and votes every edge pixel into a (theta, rho) accumulator over 8 fixed angles. It then scans the accumulator for the strongest line and presents that peak, the delayed frame, and an optional line overlay to the next stage.

## Interface
- IMAGE_BITS, 8, bits per pixel
- MATRIX_N, 120, pixels across (x)
- MATRIX_M, 120, pixels down (y)
- THRESHOLD, 128, a pixel is an edge when its value is >= THRESHOLD
- VOTE_BITS, 8, accumulator bin width (saturating)
- N_RHO (derived), 2*MATRIX_N+MATRIX_M, rho bins per angle
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ImgMatIn  in  IMAGE_BITS*MATRIX_N*MATRIX_M  frame; pixel p=y*MATRIX_N+x sits at [p*IMAGE_BITS +: IMAGE_BITS]
- ReqIn  in  1  previous stage has a valid frame
- AckIn  out  1  one-cycle pulse; frame captured this cycle
- ReqOut  out  1  result valid; held until AckOut
- AckOut  in  1  next stage accepts the result
- ImgMatOut  out  same as ImgMatIn  captured frame
- PeakTheta  out  3  winning angle index (angle = index*22.5°)
- PeakRho  out  clog2(N_RHO)  winning rho bin index
- PeakVotes  out  VOTE_BITS  vote count of the winning bin
- OverlayMat  out  MATRIX_N*MATRIX_M  bit p set when pixel p lies on the peak line

## Operation
- States: IDLE, VOTE, SCAN, OVERLAY, DONE.
- IDLE: when ReqIn=1, assert AckIn for 1 cycle, register ImgMatIn into ImgMatOut, clear pixel/theta counters, go to VOTE.
- VOTE: walk p=0..MATRIX_N*MATRIX_M-1.
  - A non-edge pixel costs 1 cycle.
  - An edge pixel costs 8 cycles, one per theta t=0..7, each incrementing bin [t][idx] once.
  - The increment saturates at 2^VOTE_BITS-1.
- Rho arithmetic:
  - raw = x*C[t] + y*S[t], signed.
  - Q1.7 tables, C = 128,118,91,49,0,-49,-91,-118 and S = 0,49,91,118,128,118,91,49.
  - idx = (raw >>> 7) + MATRIX_N, arithmetic floor shift. idx is always in [0, N_RHO).
- SCAN: read bins theta-major, rho ascending, one bin per cycle (8*N_RHO cycles). Each bin is zeroed as it is read.
  - A bin replaces the running peak only if strictly greater, so ties keep the earliest bin.
  - The running peak initialises to theta 0, rho 0, votes 0.
- OVERLAY: present only when compiled in (see Configuration). Otherwise SCAN goes directly to DONE.
- DONE: ReqOut=1 with PeakTheta, PeakRho, PeakVotes, ImgMatOut and OverlayMat stable. On AckOut=1, ReqOut drops next cycle and the state returns to IDLE.
- ReqIn is ignored outside IDLE. If ReqIn is still high on return to IDLE, a new capture starts at once.

## Timing
- Reset values: every output 0, all accumulator bins 0, state IDLE.
- Reset asserted in any state aborts the frame immediately. No partial result is emitted, and the accumulator is clean afterwards.
- Latency from the AckIn cycle to the first ReqOut cycle: 1 + P + 7*E + 8*N_RHO + 1 cycles.
  - P = pixel count, E = edge-pixel count.
  - Add P cycles when OVERLAY is compiled in.
- All outputs are registered. ReqOut is registered and changes only on state entry/exit.
- AckIn is never high two consecutive cycles.

## Configuration
- HOUGH_OVERLAY_EN defined:
  - OVERLAY walks all pixels once, 1 cycle each.
  - It sets OverlayMat[p] = edge(p) && idx(p, PeakTheta) == PeakRho.
- HOUGH_OVERLAY_EN undefined:
  - No OVERLAY state and no overlay logic.
  - OverlayMat is tied to 0.

## Test plan
All scenarios use MATRIX_N=MATRIX_M=4, IMAGE_BITS=8, THRESHOLD=128, N_RHO=12.
- Reset asserted at random points, including mid-VOTE: all outputs 0 and state IDLE. The next frame gives correct results (accumulator cleared).
- All-zero frame: AckIn pulse, then ReqOut after 1+16+96+1 cycles (without overlay), with PeakTheta=0, PeakRho=0, PeakVotes=0.
- Vertical line, x=2 pixels = 0xFF, others 0: PeakTheta=0, PeakRho=6, PeakVotes=4. Latency is 1+16+28+96+1 cycles. With HOUGH_OVERLAY_EN, OverlayMat=16'h4444.
- Horizontal line at y=1: PeakTheta=4, PeakRho=5, PeakVotes=4. With the macro, OverlayMat=16'h00F0.
- Same vertical line with VOTE_BITS=2: PeakVotes=3 (saturated), PeakTheta=0, PeakRho=6.
- Backpressure: hold AckOut=0 for 20 cycles in DONE, then ReqIn held high with a second frame.
  - ReqOut and all outputs must stay stable through the stall.
  - After the AckOut pulse, the second result must match the second frame alone, proving the bins were cleared.

Source files
------------

// File: rtl/hough_line_transform.sv
// Streaming Hough line detector: frame capture, edge threshold + voting, peak scan, optional overlay.
// Optional line overlay is compiled in with `define HOUGH_OVERLAY_EN.

module hough_line_transform #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 120,
    parameter int MATRIX_M   = 120,
    parameter int THRESHOLD  = 128,
    parameter int VOTE_BITS  = 8,
    localparam int N_RHO     = 2 * MATRIX_N + MATRIX_M,
    localparam int RHO_W     = $clog2(N_RHO),
    localparam int PIXELS    = MATRIX_N * MATRIX_M,
    localparam int FRAME_W   = IMAGE_BITS * PIXELS
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [FRAME_W-1:0]   ImgMatIn,
    input  logic                 ReqIn,
    output logic                 AckIn,
    output logic                 ReqOut,
    input  logic                 AckOut,
    output logic [FRAME_W-1:0]   ImgMatOut,
    output logic [2:0]           PeakTheta,
    output logic [RHO_W-1:0]     PeakRho,
    output logic [VOTE_BITS-1:0] PeakVotes,
    output logic [PIXELS-1:0]    OverlayMat
);

    localparam int X_W  = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;
    localparam int Y_W  = (MATRIX_M > 1) ? $clog2(MATRIX_M) : 1;
    localparam int P_W  = $clog2(PIXELS + 1);
    localparam int PI_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int FB_W = $clog2(FRAME_W);
    localparam logic [IMAGE_BITS-1:0] THR    = IMAGE_BITS'(THRESHOLD);
    localparam logic [P_W-1:0]        P_END  = P_W'(PIXELS);
    localparam logic [X_W-1:0]        X_LAST = X_W'(MATRIX_N - 1);

`ifdef HOUGH_OVERLAY_EN
    typedef enum logic [2:0] {IDLE, VOTE, SCAN, OVERLAY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, VOTE, SCAN, DONE} state_t;
`endif

    state_t state, state_nx;

    logic [VOTE_BITS-1:0] acc [8][N_RHO];

    // Shared pixel walker: VOTE fetch pointer, reused by OVERLAY.
    logic [P_W-1:0]        fp;
    logic [PI_W-1:0]       fp_idx;
    logic [X_W-1:0]        fx, fx_nx;
    logic [Y_W-1:0]        fy, fy_nx;
    logic [FB_W-1:0]       pix_base;
    logic [IMAGE_BITS-1:0] pix;
    logic                  pix_edge;

    logic                  cur_valid, cur_edge;
    logic [X_W-1:0]        cur_x;
    logic [Y_W-1:0]        cur_y;
    logic [2:0]            theta;
    logic [RHO_W-1:0]      vote_idx;
    logic                  advance, vote_last;

    logic [3:0]            scan_t;
    logic [RHO_W-1:0]      scan_r;
    logic                  scan_last;
    logic                  rd_valid;
    logic [VOTE_BITS-1:0]  rd_votes;
    logic [2:0]            rd_t;
    logic [RHO_W-1:0]      rd_r;

    logic [2:0]            best_t, cand_t;
    logic [RHO_W-1:0]      best_r, cand_r;
    logic [VOTE_BITS-1:0]  best_v, cand_v;

    // rho bin for pixel (x,y) at angle t: floor((x*cos + y*sin) / 128) + MATRIX_N, Q1.7 tables
    function automatic logic [RHO_W-1:0] rho_idx(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y,
                                                 input logic [2:0]     t);
        logic signed [31:0] c, s, raw;
        case (t)
            3'd0:    begin c = 128;  s = 0;   end
            3'd1:    begin c = 118;  s = 49;  end
            3'd2:    begin c = 91;   s = 91;  end
            3'd3:    begin c = 49;   s = 118; end
            3'd4:    begin c = 0;    s = 128; end
            3'd5:    begin c = -49;  s = 118; end
            3'd6:    begin c = -91;  s = 91;  end
            default: begin c = -118; s = 49;  end
        endcase
        raw = $signed(32'(x)) * c + $signed(32'(y)) * s;
        return RHO_W'((raw >>> 7) + MATRIX_N);
    endfunction

    assign fp_idx   = fp[PI_W-1:0];
    assign pix_base = FB_W'(fp_idx * IMAGE_BITS);
    assign pix      = ImgMatOut[pix_base +: IMAGE_BITS];
    assign pix_edge = (pix >= THR);

    assign vote_idx  = rho_idx(cur_x, cur_y, theta);
    assign advance   = !cur_valid || !cur_edge || (theta == 3'd7);
    assign vote_last = advance && (fp == P_END);
    assign scan_last = (scan_t == 4'd8);

    always_comb begin
        fx_nx = fx + X_W'(1);
        fy_nx = fy;
        if (fx == X_LAST) begin
            fx_nx = '0;
            fy_nx = fy + Y_W'(1);
        end
    end

    always_comb begin
        cand_t = best_t;
        cand_r = best_r;
        cand_v = best_v;
        if (rd_valid && (rd_votes > best_v)) begin
            cand_t = rd_t;
            cand_r = rd_r;
            cand_v = rd_votes;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ReqIn)     state_nx = VOTE;
            VOTE: if (vote_last) state_nx = SCAN;
`ifdef HOUGH_OVERLAY_EN
            SCAN:    if (scan_last)                   state_nx = OVERLAY;
            OVERLAY: if (fp == P_W'(PIXELS - 1))     state_nx = DONE;
`else
            SCAN: if (scan_last) state_nx = DONE;
`endif
            DONE: if (AckOut)    state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

`ifdef HOUGH_OVERLAY_EN
    logic ov_hit;
    assign ov_hit = pix_edge && (rho_idx(fx, fy, PeakTheta) == PeakRho);
`else
    assign OverlayMat = '0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            AckIn     <= 1'b0;
            ReqOut    <= 1'b0;
            ImgMatOut <= '0;
            PeakTheta <= '0;
            PeakRho   <= '0;
            PeakVotes <= '0;
`ifdef HOUGH_OVERLAY_EN
            OverlayMat <= '0;
`endif
            fp        <= '0;
            fx        <= '0;
            fy        <= '0;
            cur_valid <= 1'b0;
            cur_edge  <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            theta     <= '0;
            scan_t    <= '0;
            scan_r    <= '0;
            rd_valid  <= 1'b0;
            rd_votes  <= '0;
            rd_t      <= '0;
            rd_r      <= '0;
            best_t    <= '0;
            best_r    <= '0;
            best_v    <= '0;
            for (int unsigned t = 0; t < 8; t++)
                for (int unsigned r = 0; r < N_RHO; r++)
                    acc[t][r] <= '0;
        end else begin
            AckIn    <= (state == IDLE) && ReqIn;
            ReqOut   <= (state_nx == DONE);
            rd_valid <= 1'b0;
            case (state)
                IDLE: if (ReqIn) begin
                    ImgMatOut <= ImgMatIn;
                    fp        <= '0;
                    fx        <= '0;
                    fy        <= '0;
                    theta     <= '0;
                    cur_valid <= 1'b0;
                    scan_t    <= '0;
                    scan_r    <= '0;
                    best_t    <= '0;
                    best_r    <= '0;
                    best_v    <= '0;
                end
                // One-pixel fetch register ahead of the voter; the next pixel loads on the
                // cycle the current one finishes its last angle.
                VOTE: begin
                    if (cur_valid && cur_edge) begin
                        if (acc[theta][vote_idx] != '1)
                            acc[theta][vote_idx] <= acc[theta][vote_idx] + VOTE_BITS'(1);
                        theta <= theta + 3'd1;
                    end
                    if (advance) begin
                        if (fp != P_END) begin
                            cur_x     <= fx;
                            cur_y     <= fy;
                            cur_edge  <= pix_edge;
                            cur_valid <= 1'b1;
                            fp        <= fp + P_W'(1);
                            fx        <= fx_nx;
                            fy        <= fy_nx;
                        end else begin
                            cur_valid <= 1'b0;
                        end
                    end
                end
                // Bin read is registered and compared a cycle later, hence one drain cycle.
                SCAN: begin
                    best_t <= cand_t;
                    best_r <= cand_r;
                    best_v <= cand_v;
                    if (!scan_last) begin
                        rd_votes <= acc[scan_t[2:0]][scan_r];
                        acc[scan_t[2:0]][scan_r] <= '0;
                        rd_t     <= scan_t[2:0];
                        rd_r     <= scan_r;
                        rd_valid <= 1'b1;
                        if (scan_r == RHO_W'(N_RHO - 1)) begin
                            scan_r <= '0;
                            scan_t <= scan_t + 4'd1;
                        end else begin
                            scan_r <= scan_r + RHO_W'(1);
                        end
                    end else begin
                        PeakTheta <= cand_t;
                        PeakRho   <= cand_r;
                        PeakVotes <= cand_v;
                        fp        <= '0;
                        fx        <= '0;
                        fy        <= '0;
                    end
                end
`ifdef HOUGH_OVERLAY_EN
                OVERLAY: begin
                    OverlayMat[fp_idx] <= ov_hit;
                    fp <= fp + P_W'(1);
                    fx <= fx_nx;
                    fy <= fy_nx;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
